// File: rtl/ball_motion_engine.sv
// Frame-rate pong ball physics: wall/paddle reflection, miss detection,
// scoring and serve/hold/game-over sequencing.
module ball_motion_engine #(
  parameter logic [15:0] SPEED_X       = 16'd4,
  parameter logic [15:0] SPEED_Y       = 16'd2,
  parameter logic [15:0] PADDLE_HEIGHT = 16'd100,
  parameter logic [7:0]  HOLD_TICKS    = 8'd30,
  parameter logic [3:0]  WIN_SCORE     = 4'd9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        serve,
  input  logic [31:0] dimensions,
  input  logic [31:0] leftPaddle,
  input  logic [31:0] rightPaddle,
  output logic [31:0] ballPosition,
  output logic [3:0]  scoreLeft,
  output logic [3:0]  scoreRight,
  output logic        pointPulse,
  output logic        inPlay,
  output logic        gameOver
);

  typedef enum logic [1:0] {IDLE, PLAY, SCORED, OVER} state_t;

  state_t      state;
  state_t      next_state;

  logic [15:0] ball_x;
  logic [15:0] ball_y;
  logic        dir_x;
  logic        dir_y;
  logic [3:0]  score_left;
  logic [3:0]  score_right;
  logic        point_pulse;
  logic [7:0]  hold_cnt;

  logic [15:0] height;
  logic [15:0] centre_x;
  logic [15:0] centre_y;
  logic [15:0] left_x;
  logic [15:0] left_y;
  logic [15:0] right_x;
  logic [15:0] right_y;
  logic        unused_bits;

  logic [15:0] x_next;
  logic [15:0] y_next;
  logic        dir_x_next;
  logic        dir_y_next;
  logic        left_hit;
  logic        right_hit;
  logic        miss_left;
  logic        miss_right;
  logic        hold_last;
  logic        someone_won;

  assign height      = dimensions[15:0];
  assign centre_x    = {1'b0, dimensions[31:17]};
  assign centre_y    = {1'b0, dimensions[15:1]};
  assign left_x      = leftPaddle[31:16];
  assign left_y      = leftPaddle[15:0];
  assign right_x     = rightPaddle[31:16];
  assign right_y     = rightPaddle[15:0];
  assign unused_bits = dimensions[16];

  // Paddle span is inclusive at both ends; compare in 17 bits so top+height cannot wrap.
  assign left_hit  = ({1'b0, left_y} <= {1'b0, ball_y}) &&
                     ({1'b0, ball_y} <= ({1'b0, left_y} + {1'b0, PADDLE_HEIGHT}));
  assign right_hit = ({1'b0, right_y} <= {1'b0, ball_y}) &&
                     ({1'b0, ball_y} <= ({1'b0, right_y} + {1'b0, PADDLE_HEIGHT}));

  assign hold_last   = (hold_cnt == (HOLD_TICKS - 8'd1));
  assign someone_won = (score_left == WIN_SCORE) || (score_right == WIN_SCORE);

  always_comb begin
    y_next     = ball_y;
    dir_y_next = dir_y;
    if (!dir_y) begin
      if (ball_y < SPEED_Y) begin
        dir_y_next = 1'b1;
      end else begin
        y_next = ball_y - SPEED_Y;
      end
    end else begin
      if (({1'b0, ball_y} + {1'b0, SPEED_Y}) > ({1'b0, height} - 17'd1)) begin
        dir_y_next = 1'b0;
      end else begin
        y_next = ball_y + SPEED_Y;
      end
    end
  end

  // On a miss dx already points at the conceding side, so it is simply left alone.
  always_comb begin
    x_next     = ball_x;
    dir_x_next = dir_x;
    miss_left  = 1'b0;
    miss_right = 1'b0;
    if (!dir_x) begin
      if ({1'b0, ball_x} <= ({1'b0, left_x} + {1'b0, SPEED_X})) begin
        if (left_hit) begin
          dir_x_next = 1'b1;
        end else begin
          miss_left = 1'b1;
        end
      end else begin
        x_next = ball_x - SPEED_X;
      end
    end else begin
      if (({1'b0, ball_x} + {1'b0, SPEED_X}) >= {1'b0, right_x}) begin
        if (right_hit) begin
          dir_x_next = 1'b0;
        end else begin
          miss_right = 1'b1;
        end
      end else begin
        x_next = ball_x + SPEED_X;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (serve) begin
          next_state = PLAY;
        end
      end
      PLAY: begin
        if (tick && (miss_left || miss_right)) begin
          next_state = SCORED;
        end
      end
      SCORED: begin
        if (tick && hold_last) begin
          next_state = someone_won ? OVER : IDLE;
        end
      end
      default: next_state = state;
    endcase
  end

  always_comb begin
    inPlay   = (state == PLAY);
    gameOver = (state == OVER);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ball_x      <= centre_x;
      ball_y      <= centre_y;
      dir_x       <= 1'b1;
      dir_y       <= 1'b1;
      score_left  <= 4'd0;
      score_right <= 4'd0;
      point_pulse <= 1'b0;
      hold_cnt    <= 8'd0;
    end else begin
      point_pulse <= 1'b0;
      case (state)
        IDLE: begin
          ball_x <= centre_x;
          ball_y <= centre_y;
        end
        PLAY: begin
          if (tick) begin
            ball_x <= x_next;
            ball_y <= y_next;
            dir_x  <= dir_x_next;
            dir_y  <= dir_y_next;
            if (miss_left) begin
              score_right <= score_right + 4'd1;
              point_pulse <= 1'b1;
            end
            if (miss_right) begin
              score_left  <= score_left + 4'd1;
              point_pulse <= 1'b1;
            end
          end
        end
        SCORED: begin
          if (tick) begin
            if (hold_last) begin
              hold_cnt <= 8'd0;
              if (!someone_won) begin
                ball_x <= centre_x;
                ball_y <= centre_y;
              end
            end else begin
              hold_cnt <= hold_cnt + 8'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign ballPosition = {ball_x, ball_y};
  assign scoreLeft    = score_left;
  assign scoreRight   = score_right;
  assign pointPulse   = point_pulse;

endmodule

// File: tb/tb_ball_motion_engine.sv
// Directed bench for ball_motion_engine: an integer-arithmetic game model is
// compared every cycle, with hand-computed literals pinning key points.
module tb_ball_motion_engine;

  localparam int SX   = 4;
  localparam int SY   = 2;
  localparam int PH   = 100;
  localparam int HOLD = 30;
  localparam int WIN  = 2;

  localparam int S_IDLE   = 0;
  localparam int S_PLAY   = 1;
  localparam int S_SCORED = 2;
  localparam int S_OVER   = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick = 1'b0;
  logic        serve = 1'b0;
  logic [31:0] dimensions = 32'h028001E0;
  logic [31:0] leftPaddle = {16'd20, 16'd0};
  logic [31:0] rightPaddle = {16'd620, 16'd350};
  logic [31:0] ballPosition;
  logic [3:0]  scoreLeft;
  logic [3:0]  scoreRight;
  logic        pointPulse;
  logic        inPlay;
  logic        gameOver;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int m_state, m_bx, m_by, m_sl, m_sr, m_ticks_held;
  bit m_dx, m_dy, m_pulse;
  int w, h, nx, ny, lx, ly, rx, ry;

  always #5 clk = ~clk;

  ball_motion_engine #(.WIN_SCORE(4'd2)) dut (
    .clk(clk), .rst(rst), .tick(tick), .serve(serve),
    .dimensions(dimensions), .leftPaddle(leftPaddle), .rightPaddle(rightPaddle),
    .ballPosition(ballPosition), .scoreLeft(scoreLeft), .scoreRight(scoreRight),
    .pointPulse(pointPulse), .inPlay(inPlay), .gameOver(gameOver)
  );

  // Game model: a move is tried, and if it would leave the court or pass a paddle face it is refused.
  always @(posedge clk) begin
    w = int'(dimensions[31:16]);
    h = int'(dimensions[15:0]);
    if (!rst) begin
      m_state = S_IDLE; m_bx = w / 2; m_by = h / 2; m_dx = 1; m_dy = 1;
      m_sl = 0; m_sr = 0; m_pulse = 0; m_ticks_held = 0;
    end else begin
      m_pulse = 0;
      case (m_state)
        S_IDLE: begin
          m_bx = w / 2; m_by = h / 2;
          if (serve) m_state = S_PLAY;
        end
        S_PLAY: if (tick) begin
          lx = int'(leftPaddle[31:16]);  ly = int'(leftPaddle[15:0]);
          rx = int'(rightPaddle[31:16]); ry = int'(rightPaddle[15:0]);
          nx = m_bx + (m_dx ? SX : -SX);
          if (!m_dx && nx <= lx) begin
            if (m_by >= ly && m_by <= ly + PH) m_dx = 1;
            else begin m_sr++; m_pulse = 1; m_state = S_SCORED; end
          end else if (m_dx && nx >= rx) begin
            if (m_by >= ry && m_by <= ry + PH) m_dx = 0;
            else begin m_sl++; m_pulse = 1; m_state = S_SCORED; end
          end else begin
            m_bx = nx;
          end
          ny = m_by + (m_dy ? SY : -SY);
          if (ny < 0 || ny > h - 1) m_dy = !m_dy;
          else m_by = ny;
        end
        S_SCORED: if (tick) begin
          m_ticks_held++;
          if (m_ticks_held == HOLD) begin
            m_ticks_held = 0;
            if (m_sl == WIN || m_sr == WIN) m_state = S_OVER;
            else begin m_state = S_IDLE; m_bx = w / 2; m_by = h / 2; end
          end
        end
        default: ;
      endcase
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("model_ballPosition", ballPosition, {m_bx[15:0], m_by[15:0]});
      check_output("model_scoreLeft", {28'd0, scoreLeft}, m_sl);
      check_output("model_scoreRight", {28'd0, scoreRight}, m_sr);
      check_output("model_pointPulse", {31'd0, pointPulse}, {31'd0, m_pulse});
      check_output("model_inPlay", {31'd0, inPlay}, {31'd0, m_state == S_PLAY});
      check_output("model_gameOver", {31'd0, gameOver}, {31'd0, m_state == S_OVER});
    end
  end

  // Holds reset for two edges; optionally overlaps it with tick and serve.
  task automatic apply_stimulus(input logic [31:0] dims, input logic [31:0] lp,
                                input logic [31:0] rp, input logic with_strobes);
    @(negedge clk);
    rst = 1'b0; tick = with_strobes; serve = with_strobes;
    dimensions = dims; leftPaddle = lp; rightPaddle = rp;
    @(negedge clk);
    tick = 1'b0; serve = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_en = 1'b1;
  endtask

  task automatic apply_tick();
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
  endtask

  task automatic apply_ticks(input int n);
    repeat (n) apply_tick();
  endtask

  task automatic apply_serve();
    @(negedge clk); serve = 1'b1;
    @(negedge clk); serve = 1'b0;
  endtask

  initial begin
    apply_stimulus(32'h028001E0, {16'd20, 16'd0}, {16'd620, 16'd350}, 1'b0);
    check_output("reset_ball", ballPosition, 32'h014000F0);
    check_output("reset_scoreLeft", {28'd0, scoreLeft}, 32'd0);
    check_output("reset_scoreRight", {28'd0, scoreRight}, 32'd0);
    check_output("reset_inPlay", {31'd0, inPlay}, 32'd0);
    check_output("reset_pointPulse", {31'd0, pointPulse}, 32'd0);

    @(negedge clk); serve = 1'b1; tick = 1'b1;
    @(negedge clk); serve = 1'b0; tick = 1'b0;
    check_output("serve_tick_unmoved", ballPosition, 32'h014000F0);
    check_output("serve_inPlay", {31'd0, inPlay}, 32'd1);
    apply_tick();
    check_output("first_tick", ballPosition, 32'h014400F2);

    apply_ticks(73);
    check_output("tick74", ballPosition, 32'h02680184);
    apply_tick();
    check_output("tick75_right_hit", ballPosition, 32'h02680186);
    apply_tick();
    check_output("tick76_rebound", ballPosition, 32'h02640188);
    apply_ticks(160);
    check_output("left_miss_scoreRight", {28'd0, scoreRight}, 32'd1);
    check_output("left_miss_scoreLeft", {28'd0, scoreLeft}, 32'd0);

    apply_stimulus(32'h028001E0, {16'd20, 16'd0}, {16'd620, 16'd0}, 1'b0);
    apply_serve();
    apply_ticks(74);
    apply_tick();
    check_output("right_miss_scoreLeft", {28'd0, scoreLeft}, 32'd1);
    check_output("right_miss_pulse", {31'd0, pointPulse}, 32'd1);
    check_output("right_miss_frozen", ballPosition, 32'h02680186);
    @(negedge clk);
    check_output("pulse_one_cycle", {31'd0, pointPulse}, 32'd0);
    apply_ticks(29);
    check_output("hold29_frozen", ballPosition, 32'h02680186);
    apply_tick();
    check_output("hold30_recentred", ballPosition, 32'h014000F0);
    check_output("hold30_idle", {31'd0, inPlay}, 32'd0);
    apply_serve();
    apply_tick();
    check_output("reserve_dx_right", ballPosition, 32'h014400F2);

    apply_stimulus(32'h02800100, {16'd20, 16'd0}, {16'd620, 16'd0}, 1'b0);
    apply_serve();
    apply_ticks(63);
    check_output("bottom_reach", {16'd0, ballPosition[15:0]}, 32'd254);
    apply_tick();
    check_output("bottom_hold", {16'd0, ballPosition[15:0]}, 32'd254);
    apply_tick();
    check_output("bottom_rebound", {16'd0, ballPosition[15:0]}, 32'd252);

    apply_stimulus(32'h0280000E, {16'd20, 16'd0}, {16'd620, 16'd0}, 1'b0);
    apply_serve();
    apply_ticks(10);
    check_output("top_reach", {16'd0, ballPosition[15:0]}, 32'd1);
    apply_tick();
    check_output("top_hold", {16'd0, ballPosition[15:0]}, 32'd1);
    apply_tick();
    check_output("top_rebound", {16'd0, ballPosition[15:0]}, 32'd3);

    apply_stimulus(32'h028001E0, {16'd20, 16'd0}, {16'd620, 16'd0}, 1'b0);
    repeat (2) begin
      apply_serve();
      apply_ticks(75 + HOLD);
    end
    check_output("win_gameOver", {31'd0, gameOver}, 32'd1);
    check_output("win_scoreLeft", {28'd0, scoreLeft}, 32'd2);
    apply_serve();
    apply_ticks(3);
    check_output("over_ignores_serve", {31'd0, inPlay}, 32'd0);
    check_output("over_frozen", ballPosition, 32'h02680186);

    apply_stimulus(32'h028001E0, {16'd20, 16'd0}, {16'd620, 16'd0}, 1'b0);
    check_output("over_reset_gameOver", {31'd0, gameOver}, 32'd0);
    apply_serve();
    apply_ticks(75 + 10);
    apply_stimulus(32'h028001E0, {16'd20, 16'd0}, {16'd620, 16'd0}, 1'b1);
    check_output("midscored_reset_score", {28'd0, scoreLeft}, 32'd0);
    check_output("midscored_reset_ball", ballPosition, 32'h014000F0);
    apply_serve();
    apply_ticks(75 + 29);
    check_output("hold_cleared_frozen", ballPosition, 32'h02680186);
    apply_tick();
    check_output("hold_cleared_recentre", ballPosition, 32'h014000F0);

    @(negedge clk);
    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
